connect_router_nobuffer: RTL and testbench

Bufferless two-stage ring-connect router for the hierarchical-ring NoC. It sits where a local ring meets the bridge toward another ring. Each cycle it decides whether the flit circulating on the ring stays on the ring, or leaves it into the external bridge buffer. It also merges locally injected flits into free ring slots, and it never stores a flit beyond its pipeline registers.

---
 rtl/connect_router_nobuffer.sv | 64 ++++++
 tb/tb_connect_router_nobuffer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/connect_router_nobuffer.sv
// Bufferless two-stage ring/bridge connect router: a ring flit either stays on
// the ring or exits to the bridge buffer, and local flits fill free ring slots.
module connect_router_nobuffer #(
    parameter logic [1:0] RING_ID = 2'd1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [143:0] port_in,
    input  logic [143:0] inj,
    input  logic         bfull,
    output logic [143:0] port_out,
    output logic [143:0] eject,
    output logic         push,
    output logic         accept
);
    localparam int VLD = 12;

    logic [143:0] in_q;
    logic [143:0] port_out_q, port_out_d;
    logic [143:0] eject_q, eject_d;
    logic         push_q, push_d;

    logic in_vld, want_exit, do_eject, slot_free, acc;

    assign in_vld    = in_q[VLD];
    assign want_exit = in_vld && (in_q[3:2] != RING_ID);
    assign do_eject  = want_exit && !bfull;
    // Ring flits own the slot unless they leave this cycle; injection fills the rest.
    assign slot_free = !in_vld || do_eject;
    assign acc       = !rst && slot_free && inj[VLD];

    always_comb begin
        port_out_d = '0;
        eject_d    = '0;
        push_d     = 1'b0;
        if (do_eject) begin
            eject_d = in_q;
            push_d  = 1'b1;
        end
        if (!slot_free)
            port_out_d = in_q;
        else if (acc)
            port_out_d = inj;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q       <= '0;
            port_out_q <= '0;
            eject_q    <= '0;
            push_q     <= 1'b0;
        end else begin
            in_q       <= port_in;
            port_out_q <= port_out_d;
            eject_q    <= eject_d;
            push_q     <= push_d;
        end
    end

    assign port_out = port_out_q;
    assign eject    = eject_q;
    assign push     = push_q;
    assign accept   = acc;
endmodule

// File: tb/tb_connect_router_nobuffer.sv
// Directed bench for connect_router_nobuffer: a per-cycle reference model of the
// routing rules plus literal checks on the documented scenarios.
module tb_connect_router_nobuffer;
    localparam logic [1:0] RING = 2'd1;

    logic         clk = 1'b0;
    logic         rst;
    logic [143:0] port_in, inj;
    logic         bfull;
    logic [143:0] port_out, eject;
    logic         push, accept;

    connect_router_nobuffer #(.RING_ID(RING)) dut (
        .clk(clk), .rst(rst), .port_in(port_in), .inj(inj), .bfull(bfull),
        .port_out(port_out), .eject(eject), .push(push), .accept(accept)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state: the ring flit that arrived one edge ago
    logic [143:0] m_prev;
    logic [143:0] m_po, m_ej;
    logic         m_push, m_acc;
    logic         acc_seen;

    localparam logic [143:0] F1  = 144'h0111_1111_1111_1111_1111_1111_1111_1111_1852; // dst 2 -> exits
    localparam logic [143:0] FP  = 144'hBEEF_0000_1234_5678_9ABC_DEF0_0F0F_F0F0_1346; // dst 6 -> stays
    localparam logic [143:0] FI  = 144'hA5A5_5A5A_C3C3_3C3C_0102_0304_0506_0708_1A13; // inject
    localparam logic [143:0] F0  = 144'h0000_0000_0000_0000_0000_0000_0000_0000_F00C; // valid, ring 3
    localparam logic [143:0] FG  = 144'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_EFFF; // invalid junk
    localparam logic [143:0] FI2 = 144'h1234_0000_0000_0000_0000_0000_0000_4321_5147; // inject, ring 1

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // What the spec says happens at the decision edge, given the ring flit seen one edge ago.
    task automatic model_eval();
        bit valid_ring, leaves;
        valid_ring = m_prev[12];
        leaves     = valid_ring && (m_prev[3:2] != RING);
        m_po = '0; m_ej = '0; m_push = 0; m_acc = 0;
        if (rst) return;
        if (leaves && !bfull) begin
            m_ej = m_prev; m_push = 1;
        end
        if (valid_ring && !(leaves && !bfull)) m_po = m_prev;
        else if (inj[12]) begin
            m_acc = 1; m_po = inj;
        end
    endtask

    task automatic step(input logic [143:0] pin, input logic [143:0] ij,
                        input logic bf, input logic r);
        port_in = pin; inj = ij; bfull = bf; rst = r;
        #2;
        model_eval();
        acc_seen = accept;
        chk("accept", {143'b0, accept}, {143'b0, m_acc});
        @(posedge clk);
        #1;
        chk("port_out", port_out, m_po);
        chk("eject", eject, m_ej);
        chk("push", {143'b0, push}, {143'b0, m_push});
        m_prev = r ? '0 : pin;
    endtask

    initial begin
        m_prev = '0;
        port_in = '0; inj = '0; bfull = 0; rst = 1;
        @(posedge clk); #1;
        step('0, '0, 0, 1);
        chk("reset port_out", port_out, '0);
        chk("reset push", {143'b0, push}, '0);

        // eject
        step(F1, '0, 0, 0);
        chk("eject e1 port_out", port_out, '0);
        chk("eject e1 eject", eject, '0);
        step('0, '0, 0, 0);
        chk("eject e2 eject", eject, F1);
        chk("eject e2 push", {143'b0, push}, 144'd1);
        chk("eject e2 port_out", port_out, '0);

        // deflect
        step(F1, '0, 1, 0);
        step('0, '0, 1, 0);
        chk("deflect port_out", port_out, F1);
        chk("deflect push", {143'b0, push}, '0);
        chk("deflect eject", eject, '0);

        // pass-through with a blocked injector, then inject into the emptied slot
        step(FP, '0, 0, 0);
        step('0, FI, 0, 0);
        chk("pass accept", {143'b0, acc_seen}, '0);
        chk("pass port_out", port_out, FP);
        step('0, FI, 0, 0);
        chk("inject accept", {143'b0, acc_seen}, 144'd1);
        chk("inject port_out", port_out, FI);

        // simultaneous eject and inject
        step(F1, '0, 0, 0);
        step('0, FI, 0, 0);
        chk("ej+inj accept", {143'b0, acc_seen}, 144'd1);
        chk("ej+inj eject", eject, F1);
        chk("ej+inj port_out", port_out, FI);

        // deflect while injecting: injector must wait
        step(F1, '0, 1, 0);
        step('0, FI, 1, 0);
        chk("defl+inj accept", {143'b0, acc_seen}, '0);
        chk("defl+inj port_out", port_out, F1);

        // invalid junk in the slot is treated as empty and never forwarded
        step(FG, '0, 0, 0);
        step('0, '0, 0, 0);
        chk("junk port_out", port_out, '0);
        chk("junk push", {143'b0, push}, '0);

        // back-to-back traffic, ring 3 and ring 1 mixes, bfull toggling
        step(F1, '0, 0, 0);
        step(FP, FI2, 1, 0);
        step(F0, FI2, 0, 0);
        step(FG, FI2, 0, 0);
        step(F1, FI2, 1, 0);
        step('0, FI2, 0, 0);
        step('0, '0, 0, 0);

        // reset mid-flight
        step(F1, '0, 0, 0);
        step('0, '0, 0, 1);
        chk("rst port_out", port_out, '0);
        chk("rst eject", eject, '0);
        step('0, '0, 0, 0);
        chk("post-rst eject", eject, '0);
        chk("post-rst push", {143'b0, push}, '0);
        step('0, '0, 0, 0);

        // short pseudo-random soak against the model
        for (int i = 0; i < 40; i++) begin
            logic [143:0] p, q;
            p = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            q = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            step(p, q, 1'($urandom), (i % 17) == 16);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
